// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer between pc, imem and decode
module fetch_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  output logic        pc_stall,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  output logic        fault,
  output logic [1:0]  fault_cause,
  input  logic        fault_clr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] cause_n;
  logic wait_tmo;
  assign wait_tmo = !imem_ack && cnt == CW'(TIMEOUT - 1);
  assign imem_req = state == REQ || state == DROP;
  assign inst_valid = state == HOLD;
  assign fault = state == FAULT;
  assign pc_stall = !(state == HOLD && dec_ready && !redirect);
  always_comb begin
    state_n = state;
    cause_n = fault_cause;
    case (state)
      IDLE:
        if (!redirect && pc_addr[1:0] != 2'd0) begin
          state_n = FAULT;
          cause_n = 2'd1;
        end else if (!redirect) state_n = REQ;
      REQ:
        if (wait_tmo) begin
          state_n = FAULT;
          cause_n = 2'd3;
        end else if (imem_ack && redirect) state_n = IDLE;
        else if (imem_ack && imem_err) begin
          state_n = FAULT;
          cause_n = 2'd2;
        end else if (imem_ack) state_n = HOLD;
        else if (redirect) state_n = DROP;
      HOLD: state_n = (redirect || dec_ready) ? IDLE : HOLD;
      DROP:
        if (wait_tmo) begin
          state_n = FAULT;
          cause_n = 2'd3;
        end else if (imem_ack) state_n = IDLE;
      FAULT:
        if (fault_clr) begin
          state_n = IDLE;
          cause_n = 2'd0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      imem_addr <= '0;
      inst <= '0;
      inst_pc <= '0;
      fault_cause <= '0;
    end else begin
      state <= state_n;
      fault_cause <= cause_n;
      cnt <= (imem_req && state_n == state) ? cnt + CW'(1) : '0;
      imem_addr <= (state == IDLE && state_n == REQ) ? pc_addr : imem_addr;
      inst <= (state == REQ && state_n == HOLD) ? imem_rdata : inst;
      inst_pc <= (state == REQ && state_n == HOLD) ? imem_addr : inst_pc;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, corner sequences and randomized model check of fetch_ctrl
module tb_fetch_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect = 1'b0;
  logic imem_ack = 1'b0;
  logic imem_err = 1'b0;
  logic dec_ready = 1'b0;
  logic fault_clr = 1'b0;
  logic [31:0] pc_addr = '0;
  logic [31:0] imem_rdata = '0;
  logic pc_stall, imem_req, inst_valid, fault;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [1:0] fault_cause;
  fetch_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_stall(pc_stall), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_err(imem_err), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .dec_ready(dec_ready), .fault(fault), .fault_cause(fault_cause), .fault_clr(fault_clr)
  );
  always #5 clk = ~clk;
  int ncmp = 0;
  int nbad = 0;
  typedef struct {
    logic r, rd, a, e, rdy, c;
    logic [31:0] p, d;
    logic x_req, x_valid, x_stall, x_fault;
    logic [31:0] x_addr, x_inst, x_ipc;
    logic [1:0] x_cause;
  } vec_t;
  vec_t tbl[$];
  bit m_busy = 0;
  bit m_drop = 0;
  bit m_have = 0;
  int m_wait = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc = '0;
  logic [1:0] m_cause = '0;
  bit silent = 0;
  function automatic void add(input logic r, input logic [31:0] p, input logic rd, a,
                              input logic [31:0] d, input logic e, rdy, c,
                              input logic x_req, input logic [31:0] x_addr, input logic x_valid,
                              input logic [31:0] x_inst, x_ipc, input logic x_stall, x_fault,
                              input logic [1:0] x_cause);
    vec_t v;
    v.r = r; v.p = p; v.rd = rd; v.a = a; v.d = d; v.e = e; v.rdy = rdy; v.c = c;
    v.x_req = x_req; v.x_addr = x_addr; v.x_valid = x_valid; v.x_inst = x_inst;
    v.x_ipc = x_ipc; v.x_stall = x_stall; v.x_fault = x_fault; v.x_cause = x_cause;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      if (nbad <= 40) $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] p, input logic rd, a,
                       input logic [31:0] d, input logic e, rdy, c);
    @(posedge clk);
    #1;
    rst_n = r; pc_addr = p; redirect = rd; imem_ack = a;
    imem_rdata = d; imem_err = e; dec_ready = rdy; fault_clr = c;
    @(negedge clk);
  endtask
  function automatic void model_step();
    if (!rst_n) begin
      m_busy = 0; m_drop = 0; m_have = 0; m_wait = 0;
      m_addr = '0; m_inst = '0; m_pc = '0; m_cause = '0;
    end else if (m_cause != 2'd0) begin
      if (fault_clr) m_cause = 2'd0;
    end else if (m_have) begin
      if (redirect || dec_ready) m_have = 0;
    end else if (m_busy) begin
      if (!imem_ack) begin
        m_wait++;
        if (m_wait == TO) begin
          m_busy = 0;
          m_cause = 2'd3;
        end else if (redirect && !m_drop) begin
          m_drop = 1;
          m_wait = 0;
        end
      end else begin
        m_busy = 0;
        if (!m_drop && !redirect && imem_err) m_cause = 2'd2;
        else if (!m_drop && !redirect) begin
          m_have = 1;
          m_inst = imem_rdata;
          m_pc = m_addr;
        end
      end
    end else if (!redirect) begin
      if (pc_addr[1:0] != 2'd0) m_cause = 2'd1;
      else begin
        m_busy = 1;
        m_drop = 0;
        m_wait = 0;
        m_addr = pc_addr;
      end
    end
  endfunction
  initial begin
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 'h13, 0, 1, 0,     1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 1, 'h13, 0, 0, 0, 0);
    add(1, 4, 0, 0, 0, 0, 0, 0,        0, 0, 0, 'h13, 0, 1, 0, 0);
    add(1, 4, 0, 1, 'hA, 0, 0, 0,      1, 4, 0, 'h13, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 4, 0, 0, 0, 0, 0, 0, 0, 4, 1, 'hA, 4, 1, 0, 0);
    add(1, 4, 0, 0, 0, 0, 1, 0,        0, 4, 1, 'hA, 4, 0, 0, 0);
    add(1, 'h15, 0, 0, 0, 0, 0, 0,     0, 4, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h20, 1, 0, 0, 0, 0, 0,     0, 4, 0, 'hA, 4, 1, 1, 1);
    add(1, 'h20, 0, 0, 0, 0, 0, 1,     0, 4, 0, 'hA, 4, 1, 1, 1);
    add(1, 'h20, 0, 0, 0, 0, 0, 0,     0, 4, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h20, 0, 1, 'hdead, 1, 0, 0, 1, 'h20, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h20, 0, 0, 0, 0, 0, 1,     0, 'h20, 0, 'hA, 4, 1, 1, 2);
    add(1, 8, 0, 0, 0, 0, 0, 0,        0, 'h20, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 1, 0, 0, 0, 0, 0,     1, 8, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 0, 0, 0, 0, 0, 0,     1, 8, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 0, 1, 'hbad, 0, 0, 0, 1, 8, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 0, 0, 0, 0, 0, 0,     0, 8, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 0, 0, 0, 0, 0, 0,     1, 'h50, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 0, 1, 'h33, 0, 0, 0,  1, 'h50, 0, 'hA, 4, 1, 0, 0);
    add(1, 'h50, 1, 0, 0, 0, 1, 0,     0, 'h50, 1, 'h33, 'h50, 1, 0, 0);
    add(1, 'h60, 1, 0, 0, 0, 0, 0,     0, 'h50, 0, 'h33, 'h50, 1, 0, 0);
    add(1, 'h60, 0, 0, 0, 0, 0, 0,     0, 'h50, 0, 'h33, 'h50, 1, 0, 0);
    add(1, 'h60, 1, 1, 'h44, 0, 0, 0,  1, 'h60, 0, 'h33, 'h50, 1, 0, 0);
    add(1, 'h64, 0, 0, 0, 0, 1, 0,     0, 'h60, 0, 'h33, 'h50, 1, 0, 0);
    add(0, 'h64, 0, 0, 0, 0, 0, 0,     1, 'h64, 0, 'h33, 'h50, 1, 0, 0);
    add(0, 'h64, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 'h100, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 'h100, 0, 0, 0, 0, 0, 0,    1, 'h100, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].p, tbl[n].rd, tbl[n].a, tbl[n].d, tbl[n].e, tbl[n].rdy, tbl[n].c);
      chk($sformatf("v%0d_req", n), imem_req, tbl[n].x_req);
      chk($sformatf("v%0d_addr", n), imem_addr, tbl[n].x_addr);
      chk($sformatf("v%0d_valid", n), inst_valid, tbl[n].x_valid);
      chk($sformatf("v%0d_inst", n), inst, tbl[n].x_inst);
      chk($sformatf("v%0d_ipc", n), inst_pc, tbl[n].x_ipc);
      chk($sformatf("v%0d_stall", n), pc_stall, tbl[n].x_stall);
      chk($sformatf("v%0d_fault", n), fault, tbl[n].x_fault);
      chk($sformatf("v%0d_cause", n), fault_cause, tbl[n].x_cause);
    end
    for (int k = 0; k < TO - 1; k++) begin
      drive(1, 'h100, 0, 0, 0, 0, 0, 0);
      chk("req_wait_req", imem_req, 1);
    end
    drive(1, 'h100, 0, 0, 0, 0, 0, 0);
    chk("req_tmo_fault", fault, 1);
    chk("req_tmo_cause", fault_cause, 3);
    chk("req_tmo_req", imem_req, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_fault_held", fault, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_fault", fault, 0);
    chk("clr_cause", fault_cause, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    chk("drop_req", imem_req, 1);
    for (int k = 0; k < TO; k++) begin
      drive(1, 'h40, 1, 0, 0, 0, 1, 0);
      chk("drop_wait_req", imem_req, 1);
      chk("drop_wait_valid", inst_valid, 0);
    end
    drive(1, 'h40, 0, 0, 0, 0, 0, 0);
    chk("drop_tmo_fault", fault, 1);
    chk("drop_tmo_cause", fault_cause, 3);
    chk("drop_tmo_req", imem_req, 0);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (i % 40 == 0) silent = ($urandom_range(0, 3) == 0);
      rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      pc_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      redirect = ($urandom_range(0, 7) == 0);
      imem_ack = m_busy && !silent && ($urandom_range(0, 2) == 0);
      imem_err = ($urandom_range(0, 5) == 0);
      imem_rdata = $urandom;
      dec_ready = ($urandom_range(0, 1) == 1);
      fault_clr = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (i > 0) begin
        chk("rnd_req", imem_req, m_busy);
        chk("rnd_valid", inst_valid, m_have);
        chk("rnd_stall", pc_stall, !(m_have && dec_ready && !redirect));
        chk("rnd_fault", fault, m_cause != 2'd0);
        chk("rnd_cause", fault_cause, m_cause);
        if (m_busy) chk("rnd_addr", imem_addr, m_addr);
        if (m_have) begin
          chk("rnd_inst", inst, m_inst);
          chk("rnd_ipc", inst_pc, m_pc);
        end
      end
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
